// File: rtl/bus_slave_port_arbiter_if.sv
// Bundle of the N-master request side and the single slave-side BUS port of one slave arbiter.
// master: drives requests and the slave response (masters + slave model); slave: the arbiter.
interface bus_slave_port_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int Nr        = 32
);
    logic [N_MASTERS-1:0]    m_req;
    logic [N_MASTERS*Nr-1:0] m_addr;
    logic [N_MASTERS-1:0]    m_cmd;
    logic [N_MASTERS*Nr-1:0] m_wdata;
    logic [N_MASTERS-1:0]    m_ack;
    logic [N_MASTERS*Nr-1:0] m_rdata;
    logic                    s_req;
    logic [Nr-1:0]           s_addr;
    logic                    s_cmd;
    logic [Nr-1:0]           s_wdata;
    logic                    s_ack;
    logic [Nr-1:0]           s_rdata;

    // Handshake: a master holds req/addr/cmd/wdata until its one-cycle m_ack; dropping req
    // before that aborts. The slave answers a held s_req with a one-cycle s_ack (rdata valid with it).
    modport master (
        output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
        input  m_ack, m_rdata, s_req, s_addr, s_cmd, s_wdata
    );
    modport slave (
        input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
        output m_ack, m_rdata, s_req, s_addr, s_cmd, s_wdata
    );
endinterface

// File: rtl/bus_slave_port_arbiter.sv
// Per-slave round-robin arbiter: grants one address-matching master at a time to the slave port
// and routes the slave's ack/rdata back to that master only.
module bus_slave_port_arbiter #(
    parameter  int N_MASTERS = 4,
    parameter  int SLAVE_ID  = 0,
    parameter  int Nr        = 32,
    localparam int GW        = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    bus_slave_port_arbiter_if.slave       bus,
    output logic [GW-1:0]                 gnt_o,
    output logic                          busy_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N_MASTERS-1:0] hit;
    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic [GW:0]          cand;
    logic [GW-1:0]        gnt_nxt;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            hit[i] = bus.m_req[i] && (bus.m_addr[i*Nr + Nr - 2 +: 2] == 2'(SLAVE_ID));
        end
    end

    // Scan downwards so the hit closest to rr_ptr (cyclically) is the one left in pick_idx.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(N_MASTERS)) cand = cand - (GW+1)'(N_MASTERS);
            if (hit[cand[GW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[GW-1:0];
            end
        end
    end

    assign gnt_nxt = (gnt_q == GW'(N_MASTERS - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Completion and abort both hand top priority to the next master in line.
                if (bus.s_ack || !bus.m_req[gnt_q]) begin
                    rr_ptr_d = gnt_nxt;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Slave-side and return paths are combinational from the grant so ack returns in the same cycle.
    always_comb begin
        bus.s_req   = 1'b0;
        bus.s_addr  = '0;
        bus.s_cmd   = 1'b0;
        bus.s_wdata = '0;
        bus.m_ack   = '0;
        bus.m_rdata = '0;
        if (state_q == BUSY) begin
            bus.s_req   = bus.m_req[gnt_q];
            bus.s_addr  = bus.m_addr[gnt_q*Nr +: Nr];
            bus.s_cmd   = bus.m_cmd[gnt_q];
            bus.s_wdata = bus.m_wdata[gnt_q*Nr +: Nr];
            if (bus.s_ack) begin
                bus.m_ack[gnt_q]             = 1'b1;
                bus.m_rdata[gnt_q*Nr +: Nr]  = bus.s_rdata;
            end
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q == BUSY);
endmodule

// File: tb/tb_bus_slave_port_arbiter.sv
// Bench for bus_slave_port_arbiter (4 masters, slave id 2): directed scenarios then random traffic,
// all outputs compared every cycle against a transaction-level model of the arbitration rules.
module tb_bus_slave_port_arbiter;
  localparam int N   = 4;
  localparam int NR  = 32;
  localparam int SID = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt_o;
  logic       busy_o;

  bus_slave_port_arbiter_if #(.N_MASTERS(N), .Nr(NR)) bus ();

  bus_slave_port_arbiter #(.N_MASTERS(N), .SLAVE_ID(SID), .Nr(NR)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .gnt_o  (gnt_o),
    .busy_o (busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: one transfer in flight, owner, and the master with top priority
  bit       mdl_busy;
  int       mdl_gnt;
  int       mdl_rr;
  int       mdl_age;
  logic [N-1:0] last_ack;
  bit       prev_busy;
  int       glog[$];
  int       ack_cnt[N];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hit(int i);
    logic [NR-1:0] a;
    a = bus.m_addr[i*NR +: NR];
    return bus.m_req[i] && (a[NR-1:NR-2] == 2'(SID));
  endfunction

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_gnt   = 0;
    mdl_rr    = 0;
    mdl_age   = 0;
    prev_busy = 1'b0;
  endtask

  // Compare every output at the falling edge against what the rules say for the current inputs.
  task automatic sample(string tag);
    logic [N-1:0]    ea;
    logic [N*NR-1:0] er;
    int g;
    @(negedge clk);
    g  = mdl_gnt;
    ea = '0;
    er = '0;
    if (mdl_busy && bus.s_ack) begin
      ea[g] = 1'b1;
      er[g*NR +: NR] = bus.s_rdata;
    end
    last_ack = ea;
    check({tag, " s_req"},   32'(bus.s_req),   mdl_busy ? 32'(bus.m_req[g]) : 32'd0);
    check({tag, " s_addr"},  bus.s_addr,       mdl_busy ? bus.m_addr[g*NR +: NR] : 32'd0);
    check({tag, " s_cmd"},   32'(bus.s_cmd),   mdl_busy ? 32'(bus.m_cmd[g]) : 32'd0);
    check({tag, " s_wdata"}, bus.s_wdata,      mdl_busy ? bus.m_wdata[g*NR +: NR] : 32'd0);
    check({tag, " m_ack"},   32'(bus.m_ack),   32'(ea));
    for (int i = 0; i < N; i++)
      check({tag, " m_rdata"}, bus.m_rdata[i*NR +: NR], er[i*NR +: NR]);
    check({tag, " gnt_o"},   32'(gnt_o),       32'(g));
    check({tag, " busy_o"},  32'(busy_o),      32'(mdl_busy));
    if (busy_o && !prev_busy) glog.push_back(int'(gnt_o));
    prev_busy = busy_o;
    for (int i = 0; i < N; i++) if (bus.m_ack[i]) ack_cnt[i]++;
  endtask

  // Model transition at the rising edge, then move to the input-drive point.
  task automatic advance();
    if (!mdl_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mdl_rr + k) % N;
        if (is_hit(i)) begin
          mdl_busy = 1'b1;
          mdl_gnt  = i;
          mdl_age  = 0;
          break;
        end
      end
    end else if (bus.s_ack || !bus.m_req[mdl_gnt]) begin
      mdl_busy = 1'b0;
      mdl_rr   = (mdl_gnt + 1) % N;
    end else begin
      mdl_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(string tag);
    sample(tag);
    advance();
  endtask

  task automatic set_m(int i, bit req, logic [31:0] a, bit c, logic [31:0] w);
    bus.m_req[i]            = req;
    bus.m_addr[i*NR +: NR]  = a;
    bus.m_cmd[i]            = c;
    bus.m_wdata[i*NR +: NR] = w;
  endtask

  task automatic clear_all();
    bus.m_req   = '0;
    bus.m_addr  = '0;
    bus.m_cmd   = '0;
    bus.m_wdata = '0;
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    model_reset();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;

    // reset state
    sample("reset");
    sample("reset2");
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin: all four hit continuously, slave acks after one BUSY cycle
    glog.delete();
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h8000_0000 + 32'(i * 16), 1'b0, 32'h0);
    for (int c = 0; c < 40 && glog.size() < 5; c++) begin
      bus.s_ack   = mdl_busy && (mdl_age >= 1);
      bus.s_rdata = 32'hA000_0000 + 32'(c);
      cycle("rr");
    end
    check("rr grant count", 32'(glog.size()), 32'd5);
    if (glog.size() == 5) begin
      check("rr order0", 32'(glog[0]), 32'd0);
      check("rr order1", 32'(glog[1]), 32'd1);
      check("rr order2", 32'(glog[2]), 32'd2);
      check("rr order3", 32'(glog[3]), 32'd3);
      check("rr order4", 32'(glog[4]), 32'd0);
    end
    for (int i = 0; i < N; i++) check("rr acks once each", 32'(ack_cnt[i]), 32'd1);
    clear_all();
    cycle("rr drain");
    cycle("rr drain");

    // single read from M1, slave answers 3 cycles after request
    set_m(1, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
    cycle("rd idle");
    sample("rd busy1");
    check("rd s_req rises", 32'(bus.s_req), 32'd1);
    advance();
    cycle("rd busy2");
    bus.s_ack = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
    sample("rd ack");
    check("rd m_ack", 32'(bus.m_ack), 32'b0010);
    check("rd m_rdata1", bus.m_rdata[1*NR +: NR], 32'hDEAD_BEEF);
    check("rd m_rdata0", bus.m_rdata[0 +: NR], 32'h0);
    advance();
    clear_all();
    cycle("rd after");

    // address filter: other slave ids are ignored, own id is granted
    set_m(0, 1'b1, 32'h4000_0000, 1'b0, 32'h0);
    cycle("flt miss1");
    cycle("flt miss2");
    set_m(0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    cycle("flt miss3");
    sample("flt miss4");
    check("flt no s_req", 32'(bus.s_req), 32'd0);
    advance();
    set_m(0, 1'b1, 32'h8000_0004, 1'b0, 32'h0);
    cycle("flt hit idle");
    sample("flt hit busy");
    check("flt s_addr", bus.s_addr, 32'h8000_0004);
    advance();
    bus.s_ack = 1'b1;
    cycle("flt ack");
    clear_all();
    cycle("flt after");

    // write passthrough from M2
    set_m(2, 1'b1, 32'h8000_0100, 1'b1, 32'h1234_5678);
    cycle("wr idle");
    sample("wr busy");
    check("wr s_cmd", 32'(bus.s_cmd), 32'd1);
    check("wr s_wdata", bus.s_wdata, 32'h1234_5678);
    check("wr no early ack", 32'(bus.m_ack), 32'd0);
    advance();
    bus.s_ack = 1'b1;
    sample("wr ack");
    check("wr m_ack2", 32'(bus.m_ack), 32'b0100);
    advance();
    clear_all();
    cycle("wr after");

    // abort: M3 granted then drops; next grant starts at M0; spurious ack in IDLE
    set_m(3, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
    cycle("ab idle");
    sample("ab busy");
    check("ab gnt3", 32'(gnt_o), 32'd3);
    advance();
    bus.m_req[3] = 1'b0;
    cycle("ab drop");
    sample("ab back idle");
    check("ab idle", 32'(busy_o), 32'd0);
    advance();
    bus.s_ack = 1'b1; bus.s_rdata = 32'h5555_AAAA;
    sample("spur ack");
    check("spur no m_ack", 32'(bus.m_ack), 32'd0);
    advance();
    bus.s_ack = 1'b0;
    set_m(3, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
    set_m(0, 1'b1, 32'h8000_0300, 1'b0, 32'h0);
    cycle("ab both idle");
    sample("ab both busy");
    check("ab next gnt0", 32'(gnt_o), 32'd0);
    advance();
    bus.s_ack = 1'b1;
    cycle("ab ack0");
    clear_all();
    cycle("ab after");

    // reset mid-BUSY: M1 in flight, outputs drop immediately, M0 wins afterwards
    set_m(1, 1'b1, 32'h8000_0040, 1'b0, 32'h0);
    cycle("mr idle");
    sample("mr busy");
    check("mr s_req before", 32'(bus.s_req), 32'd1);
    bus.s_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mr s_req", 32'(bus.s_req), 32'd0);
    check("mr gnt_o", 32'(gnt_o), 32'd0);
    check("mr m_ack", 32'(bus.m_ack), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.s_ack = 1'b0;
    set_m(0, 1'b1, 32'h8000_0080, 1'b0, 32'h0);
    cycle("mr both idle");
    sample("mr both busy");
    check("mr top prio m0", 32'(gnt_o), 32'd0);
    advance();
    clear_all();
    cycle("mr after");

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.m_req[i] && !last_ack[i]) begin
          if ($urandom_range(0, 29) == 0) bus.m_req[i] = 1'b0;
        end else if (bus.m_req[i] && last_ack[i] && $urandom_range(0, 1) == 0) begin
          bus.m_req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          logic [1:0]  top;
          logic [29:0] low;
          top = ($urandom_range(0, 1) == 0) ? 2'(SID) : 2'($urandom_range(0, 3));
          low = 30'($urandom);
          set_m(i, 1'b1, {top, low}, 1'($urandom_range(0, 1)), $urandom);
        end
      end
      bus.s_ack   = mdl_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.s_rdata = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
